// File: rtl/hazard_sched_if.sv
// hazard_sched pipeline-facing bundle: hazard inputs from ID/EX/MEM
// and the stall/flush enables driven back to the pipeline registers.
interface hazard_sched_if;
  logic [4:0]  rs1_addr_ID;
  logic [4:0]  rs2_addr_ID;
  logic [4:0]  rd_addr_EX;
  logic        mem_rd_EX;
  logic        pc_sel_EX;
  logic        md_start_EX;
  logic        dmem_req_MEM;
  logic        dmem_ack;
  logic        stall_pc;
  logic        stall_IF;
  logic        stall_ID;
  logic        stall_EX;
  logic        stall_MEM;
  logic        flush_IF;
  logic        flush_ID;
  logic        flush_EX;
  logic        flush_MEM;
  logic        md_fire;
  logic        md_busy;
  logic [31:0] stall_cycles;

  modport master (
    output rs1_addr_ID, rs2_addr_ID, rd_addr_EX,
    output mem_rd_EX, pc_sel_EX, md_start_EX,
    output dmem_req_MEM, dmem_ack,
    input  stall_pc, stall_IF, stall_ID,
    input  stall_EX, stall_MEM,
    input  flush_IF, flush_ID, flush_EX, flush_MEM,
    input  md_fire, md_busy, stall_cycles
  );

  modport slave (
    input  rs1_addr_ID, rs2_addr_ID, rd_addr_EX,
    input  mem_rd_EX, pc_sel_EX, md_start_EX,
    input  dmem_req_MEM, dmem_ack,
    output stall_pc, stall_IF, stall_ID,
    output stall_EX, stall_MEM,
    output flush_IF, flush_ID, flush_EX, flush_MEM,
    output md_fire, md_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_sched.sv
// Hazard scheduler: load-use, branch flush and multi-cycle stalls
// (mul/div latency, data-memory wait) for the 5-stage pipeline.
module hazard_sched #(
  parameter  int MD_LAT = 8,
  localparam int CNT_W  = $clog2(MD_LAT)
) (
  input  logic          clk,
  input  logic          reset,
  hazard_sched_if.slave hz
);
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [31:0]      r_stall_cycles;

  logic w_lu, w_hold, w_cnt_zero;
  logic w_br_fif, w_br_fid, w_br_stall;
  logic w_spc, w_sif, w_sid, w_sex, w_smem;
  logic w_fif, w_fid, w_fex, w_fmem;
  logic w_fire, w_busy;

  assign w_lu = hz.mem_rd_EX
             && (hz.rd_addr_EX != 5'd0)
             && ((hz.rs1_addr_ID == hz.rd_addr_EX)
              || (hz.rs2_addr_ID == hz.rd_addr_EX));

  assign w_hold     = hz.dmem_req_MEM && !hz.dmem_ack;
  assign w_cnt_zero = (r_cnt == '0);

  // Redirect decision shared by RUN and both wait-exit cycles
  assign w_br_fif   = hz.pc_sel_EX;
  assign w_br_fid   = hz.pc_sel_EX || w_lu;
  assign w_br_stall = !hz.pc_sel_EX && w_lu;

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_spc  = 1'b0;
    w_sif  = 1'b0;
    w_sid  = 1'b0;
    w_sex  = 1'b0;
    w_smem = 1'b0;
    w_fif  = 1'b0;
    w_fid  = 1'b0;
    w_fex  = 1'b0;
    w_fmem = 1'b0;
    w_fire = 1'b0;
    w_busy = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_hold) begin
          {w_spc, w_sif, w_sid, w_sex, w_smem} = '1;
          w_fmem = 1'b1;
          w_next = MEM_WAIT;
        end else if (hz.md_start_EX) begin
          {w_spc, w_sif, w_sid, w_sex} = '1;
          w_fex     = 1'b1;
          w_cnt_nxt = CNT_W'(MD_LAT - 2);
          w_next    = MD_WAIT;
        end else begin
          w_fif = w_br_fif;
          w_fid = w_br_fid;
          w_spc = w_br_stall;
          w_sif = w_br_stall;
        end
      end
      MEM_WAIT: begin
        if (!hz.dmem_ack) begin
          {w_spc, w_sif, w_sid, w_sex, w_smem} = '1;
          w_fmem = 1'b1;
        end else begin
          w_fif  = w_br_fif;
          w_fid  = w_br_fid;
          w_spc  = w_br_stall;
          w_sif  = w_br_stall;
          w_next = RUN;
        end
      end
      MD_WAIT: begin
        if (!w_cnt_zero) begin
          {w_spc, w_sif, w_sid, w_sex} = '1;
          w_fex     = 1'b1;
          w_busy    = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_fire = 1'b1;
          w_fif  = w_br_fif;
          w_fid  = w_br_fid;
          w_spc  = w_br_stall;
          w_sif  = w_br_stall;
          w_next = RUN;
        end
      end
      default: w_next = RUN;
    endcase
  end

  // Outputs are gated so nothing leaks out while reset is asserted
  assign hz.stall_pc     = w_spc  && !reset;
  assign hz.stall_IF     = w_sif  && !reset;
  assign hz.stall_ID     = w_sid  && !reset;
  assign hz.stall_EX     = w_sex  && !reset;
  assign hz.stall_MEM    = w_smem && !reset;
  assign hz.flush_IF     = w_fif  && !reset;
  assign hz.flush_ID     = w_fid  && !reset;
  assign hz.flush_EX     = w_fex  && !reset;
  assign hz.flush_MEM    = w_fmem && !reset;
  assign hz.md_fire      = w_fire && !reset;
  assign hz.md_busy      = w_busy && !reset;
  assign hz.stall_cycles = r_stall_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state        <= w_next;
      r_cnt          <= w_cnt_nxt;
      r_stall_cycles <= r_stall_cycles + 32'(w_spc);
    end
  end
endmodule
